cone_bist_ctrl: RTL and testbench

- Sequential built-in self-test initiator for one combinational output cone of the benchmark set, such as a partial-output cone with 22 pseudo-primary inputs and 1 output.
- Generates pseudo-random input patterns with an LFSR, drives them into the cone, and samples the cone response.
- Compacts the responses into a MISR signature and compares the signature against a golden value.
- Sits between the test-access controller and the cone under test.

---
 rtl/cone_bist_ctrl_if.sv | 29 ++
 rtl/cone_bist_ctrl.sv | 139 +++++++++++++
 tb/tb_cone_bist_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cone_bist_ctrl_if.sv
// Test-access side of the cone BIST controller: run control, sampled run
// parameters and status/signature readback.
interface cone_bist_ctrl_if #(
   parameter int unsigned N_IN  = 22,
   parameter int unsigned SIG_W = 16,
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             abort;
   logic [N_IN-1:0]  seed;
   logic [CNT_W-1:0] num_pat;
   logic [SIG_W-1:0] golden;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;

   // Test-access controller side
   modport master (
      output start, abort, seed, num_pat, golden,
      input  busy, done, pass, signature
   );

   // BIST controller side
   modport slave (
      input  start, abort, seed, num_pat, golden,
      output busy, done, pass, signature
   );
endinterface

// File: rtl/cone_bist_ctrl.sv
// BIST initiator for one combinational cone: a Fibonacci LFSR drives
// registered patterns into the cone, a MISR compacts the responses and the
// final signature is compared against a golden value.
module cone_bist_ctrl #(
   parameter int unsigned          N_IN      = 22,
   parameter int unsigned          N_OUT     = 1,
   parameter int unsigned          SIG_W     = 16,
   parameter logic [N_IN-1:0]      LFSR_TAPS = 22'h300000,
   parameter logic [SIG_W-1:0]     MISR_POLY = 16'h1021,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   cone_bist_ctrl_if.slave  tap,
   output logic [N_IN-1:0]  pat_o,
   input  logic [N_OUT-1:0] resp_i
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [N_IN-1:0]  LFSR_ONE = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic [N_IN-1:0]  lfsr_q,  lfsr_d;
   logic [N_IN-1:0]  pat_q,   pat_d;
   logic [SIG_W-1:0] misr_q,  misr_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W-1:0] npat_q,  npat_d;
   logic [SIG_W-1:0] gold_q,  gold_d;
   logic             pass_q,  pass_d;

   logic [N_IN-1:0]  lfsr_step;
   logic [SIG_W-1:0] resp_ext;
   logic [SIG_W-1:0] misr_step;

   // LFSR advance, response zero-extension and MISR compaction step
   always_comb begin
      lfsr_step = {lfsr_q[N_IN-2:0], ^(lfsr_q & LFSR_TAPS)};
      resp_ext  = '0;
      resp_ext[N_OUT-1:0] = resp_i;
      misr_step = {misr_q[SIG_W-2:0], 1'b0} ^ (misr_q[SIG_W-1] ? MISR_POLY : '0) ^ resp_ext;
   end

   // Next-state logic; abort overrides everything, including a coincident start
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      pat_d   = pat_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      npat_d  = npat_q;
      gold_d  = gold_q;
      pass_d  = pass_q;
      if (tap.abort) begin
         state_d = ST_IDLE;
         lfsr_d  = '0;
         pat_d   = '0;
         misr_d  = '0;
         cnt_d   = '0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (tap.start) begin
                  state_d = ST_LOAD;
                  npat_d  = tap.num_pat;
                  gold_d  = tap.golden;
                  // an all-zero seed would lock the LFSR up
                  lfsr_d  = (tap.seed == '0) ? LFSR_ONE : tap.seed;
                  misr_d  = '0;
                  pass_d  = 1'b0;
               end
            end
            ST_LOAD: begin
               pat_d = lfsr_q;
               cnt_d = npat_q;
               if (npat_q == '0) begin
                  state_d = ST_DONE;
                  pass_d  = (misr_q == gold_q);
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               misr_d = misr_step;
               lfsr_d = lfsr_step;
               pat_d  = lfsr_step;
               cnt_d  = cnt_q - CNT_ONE;
               // leaving at 1 means the counter never reaches below zero
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               state_d = ST_DONE;
               pass_d  = (misr_q == gold_q);
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lfsr_q  <= '0;
         pat_q   <= '0;
         misr_q  <= '0;
         cnt_q   <= '0;
         npat_q  <= '0;
         gold_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         pat_q   <= pat_d;
         misr_q  <= misr_d;
         cnt_q   <= cnt_d;
         npat_q  <= npat_d;
         gold_q  <= gold_d;
         pass_q  <= pass_d;
      end
   end

   assign tap.busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign tap.done      = (state_q == ST_DONE);
   assign tap.pass      = pass_q;
   assign tap.signature = misr_q;
   assign pat_o         = pat_q;

endmodule

// File: tb/tb_cone_bist_ctrl.sv
// Self-checking bench for cone_bist_ctrl: a bench-side cone feeds resp_i,
// a reference LFSR/MISR model queues expected patterns and results.
module tb_cone_bist_ctrl;

   localparam int unsigned N_IN  = 22;
   localparam int unsigned N_OUT = 1;
   localparam int unsigned SIG_W = 16;
   localparam int unsigned CNT_W = 16;

   typedef struct {
      logic [15:0] sig;
      logic        pass;
      int          lat;
      int          busy_cyc;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic [21:0] pat_o;
   logic [0:0]  resp_i;
   int          mode;
   int          errors;
   int          checks;

   sb_t         sb_q[$];
   logic [21:0] pat_q[$];

   cone_bist_ctrl_if #(.N_IN(N_IN), .SIG_W(SIG_W), .CNT_W(CNT_W)) tap ();

   cone_bist_ctrl #(
      .N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W),
      .LFSR_TAPS(22'h300000), .MISR_POLY(16'h1021), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tap(tap.slave), .pat_o(pat_o), .resp_i(resp_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bench-side cone: 0 = tied low, 1 = tied high, 2 = parity of a bit subset
   function automatic logic cone_fn(input logic [21:0] p, input int md);
      logic [21:0] mask;
      mask = 22'h02A5A5;
      case (md)
         0:       return 1'b0;
         1:       return 1'b1;
         default: return ^(p & mask);
      endcase
   endfunction

   always_comb resp_i[0] = cone_fn(pat_o, mode);

   function automatic logic [21:0] model_lfsr(input logic [21:0] s);
      logic [21:0] taps;
      logic        fb;
      taps = 22'h300000;
      fb   = 1'b0;
      for (int b = 0; b < 22; b++) if (taps[b]) fb = fb ^ s[b];
      return {s[20:0], fb};
   endfunction

   function automatic logic [15:0] model_sig(input logic [21:0] sd, input int n, input int md);
      logic [21:0] p;
      logic [15:0] m;
      p = (sd == 22'd0) ? 22'd1 : sd;
      m = 16'd0;
      for (int i = 0; i < n; i++) begin
         if (m[15]) m = (m << 1) ^ 16'h1021;
         else       m = m << 1;
         m[0] = m[0] ^ cone_fn(p, md);
         p = model_lfsr(p);
      end
      return m;
   endfunction

   task automatic run_test(input string name, input logic [21:0] sd, input logic [15:0] np,
                           input logic [15:0] gd, input int md, input int glitch_at);
      sb_t         e;
      logic [21:0] p;
      logic [21:0] ep;
      int          cyc;
      int          bcnt;
      bit          seen;
      mode       = md;
      e.sig      = model_sig(sd, int'(np), md);
      e.pass     = (e.sig == gd);
      e.lat      = (np == 16'd0) ? 2 : int'(np) + 3;
      e.busy_cyc = (np == 16'd0) ? 1 : int'(np) + 2;
      sb_q.push_back(e);
      p = (sd == 22'd0) ? 22'd1 : sd;
      for (int i = 0; i < int'(np); i++) begin
         pat_q.push_back(p);
         p = model_lfsr(p);
      end
      tap.seed    = sd;
      tap.num_pat = np;
      tap.golden  = gd;
      tap.start   = 1'b1;
      @(negedge clk);
      tap.start   = 1'b0;
      tap.seed    = 22'($urandom);
      tap.num_pat = 16'($urandom_range(1, 9));
      tap.golden  = 16'($urandom);
      cyc  = 1;
      bcnt = 0;
      seen = 1'b0;
      while (cyc < int'(np) + 20) begin
         if (tap.done) begin
            seen = 1'b1;
            break;
         end
         if (cyc == 1) begin
            checks++;
            if (tap.busy !== 1'b1)
               $display("FAIL %s busy_on_load: got %b want 1", name, tap.busy);
            if (tap.busy !== 1'b1) errors++;
         end
         if (tap.busy) bcnt++;
         if (cyc >= 2 && pat_q.size() > 0) begin
            ep = pat_q.pop_front();
            checks++;
            if (pat_o !== ep) begin
               errors++;
               $display("FAIL %s pat_o[%0d]: got %h want %h", name, cyc - 2, pat_o, ep);
            end
         end
         tap.start = (cyc == glitch_at);
         @(negedge clk);
         cyc++;
      end
      tap.start = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout: no done after %0d cycles, want %0d", name, cyc, e.lat);
      end else begin
         if (cyc !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
         end
         checks++;
         if (tap.signature !== e.sig) begin
            errors++;
            $display("FAIL %s signature: got %h want %h", name, tap.signature, e.sig);
         end
         checks++;
         if (tap.pass !== e.pass) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", name, tap.pass, e.pass);
         end
         checks++;
         if (bcnt !== e.busy_cyc) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, e.busy_cyc);
         end
         @(negedge clk);
         checks++;
         if (tap.done !== 1'b1 || tap.signature !== e.sig) begin
            errors++;
            $display("FAIL %s done_hold: done=%b sig=%h want done=1 sig=%h",
                     name, tap.done, tap.signature, e.sig);
         end
      end
      pat_q.delete();
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      tap.start   = 1'b0;
      tap.abort   = 1'b0;
      tap.seed    = '0;
      tap.num_pat = '0;
      tap.golden  = '0;
      mode        = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tap.busy, tap.done, tap.pass, tap.signature, pat_o} !== '0) begin
         errors++;
         $display("FAIL reset_values: busy=%b done=%b pass=%b sig=%h pat=%h want all 0",
                  tap.busy, tap.done, tap.pass, tap.signature, pat_o);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (tap.busy !== 1'b0 || tap.done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", tap.busy, tap.done);
      end
   endtask

   task automatic test_reset_mid_run;
      mode        = 2;
      tap.seed    = 22'h000005;
      tap.num_pat = 16'd100;
      tap.golden  = 16'h1234;
      tap.start   = 1'b1;
      @(negedge clk);
      tap.start = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (tap.busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_busy_before: got %b want 1", tap.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({tap.busy, tap.done, tap.pass, tap.signature, pat_o} !== '0) begin
         errors++;
         $display("FAIL rst_mid_async: busy=%b done=%b pass=%b sig=%h pat=%h want all 0",
                  tap.busy, tap.done, tap.pass, tap.signature, pat_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (tap.busy !== 1'b0 || tap.done !== 1'b0 || tap.pass !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_stays_idle: busy=%b done=%b pass=%b want 0 0 0",
                  tap.busy, tap.done, tap.pass);
      end
   endtask

   task automatic test_tied;
      run_test("tie0_n50", 22'h0ACE11, 16'd50, 16'h0000, 0, 0);
      run_test("tie1_n1_g1", 22'h000123, 16'd1, 16'h0001, 1, 0);
      run_test("tie1_n1_g2", 22'h000123, 16'd1, 16'h0002, 1, 0);
   endtask

   task automatic test_seed0;
      run_test("seed0_n3", 22'h000000, 16'd3, 16'h0000, 2, 0);
   endtask

   task automatic test_zero_and_ignored_start;
      logic [15:0] g;
      run_test("zero_g0", 22'h00F00D, 16'd0, 16'h0000, 2, 0);
      run_test("zero_g5", 22'h00F00D, 16'd0, 16'h0005, 2, 0);
      g = model_sig(22'h02F00F, 20, 2);
      run_test("start_while_busy", 22'h02F00F, 16'd20, g, 2, 9);
   endtask

   task automatic test_abort;
      logic [15:0] g;
      g = model_sig(22'h00BEEF, 8, 2);
      run_test("pre_abort", 22'h00BEEF, 16'd8, g, 2, 0);
      tap.abort = 1'b1;
      @(negedge clk);
      tap.abort = 1'b0;
      checks++;
      if ({tap.busy, tap.done, tap.pass, tap.signature, pat_o} !== '0) begin
         errors++;
         $display("FAIL abort_from_done: busy=%b done=%b pass=%b sig=%h pat=%h want all 0",
                  tap.busy, tap.done, tap.pass, tap.signature, pat_o);
      end
      mode        = 2;
      tap.seed    = 22'h1ABCDE;
      tap.num_pat = 16'd30;
      tap.golden  = 16'h0000;
      tap.start   = 1'b1;
      @(negedge clk);
      tap.start = 1'b0;
      repeat (10) @(negedge clk);
      tap.abort   = 1'b1;
      tap.start   = 1'b1;
      tap.seed    = 22'h000777;
      tap.num_pat = 16'd4;
      @(negedge clk);
      tap.abort = 1'b0;
      tap.start = 1'b0;
      checks++;
      if ({tap.busy, tap.done, tap.pass, tap.signature, pat_o} !== '0) begin
         errors++;
         $display("FAIL abort_in_run: busy=%b done=%b pass=%b sig=%h pat=%h want all 0",
                  tap.busy, tap.done, tap.pass, tap.signature, pat_o);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (tap.busy !== 1'b0 || tap.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_stays_idle: busy=%b done=%b want 0 0", tap.busy, tap.done);
      end
      g = model_sig(22'h1ABCDE, 30, 2);
      run_test("after_abort", 22'h1ABCDE, 16'd30, g, 2, 0);
   endtask

   task automatic test_back_to_back;
      logic [15:0] g;
      g = model_sig(22'h3FFFFF, 37, 2);
      run_test("b2b_a", 22'h3FFFFF, 16'd37, g, 2, 0);
      run_test("b2b_b", 22'h155555, 16'd1000, 16'hFFFF, 2, 0);
      g = model_sig(22'h200000, 12, 1);
      run_test("b2b_c", 22'h200000, 16'd12, g, 1, 0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_reset_mid_run();
      test_tied();
      test_seed0();
      test_zero_and_ignored_start();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
